// File: rtl/gpmc_reg_bank.sv
// Host-visible register bank: ID, scratch, sticky events with mask/irq, last address,
// control and status words. One-cycle registered reads, zero output on miss for OR-combining.
module gpmc_reg_bank #(
   parameter int          ADDR_WIDTH = 16,
   parameter int          DATA_WIDTH = 16,
   parameter int unsigned BASE_ADDR  = 0,
   parameter int unsigned ID_VALUE   = 32'h0000_C10D,
   parameter int          N_CTRL     = 4,
   parameter int          N_STAT     = 4,
   parameter int          N_EVENTS   = 8
) (
   input  logic                         gpmc_clk,
   input  logic                         gpmc_reset,
   input  logic                         address_valid,
   input  logic [ADDR_WIDTH-1:0]        address,
   input  logic                         wr_en,
   input  logic [DATA_WIDTH-1:0]        wr_data,
   output logic [DATA_WIDTH-1:0]        rd_data,
   input  logic [N_STAT*DATA_WIDTH-1:0] stat_in,
   input  logic [N_EVENTS-1:0]          event_in,
   output logic [N_CTRL*DATA_WIDTH-1:0] ctrl_out,
   output logic [N_CTRL-1:0]            ctrl_wr_pulse,
   output logic                         irq
);

   localparam logic [ADDR_WIDTH-1:0] LP_BASE   = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [DATA_WIDTH-1:0] LP_ID     = DATA_WIDTH'(ID_VALUE);
   localparam logic [DATA_WIDTH-1:0] LP_SCR_RV = DATA_WIDTH'(16'h1234);

   logic [DATA_WIDTH-1:0] r_rd_data;
   logic [DATA_WIDTH-1:0] r_scratch;
   logic [N_EVENTS-1:0]   r_event;
   logic [N_EVENTS-1:0]   r_mask;
   logic [DATA_WIDTH-1:0] r_last_addr;
   logic [DATA_WIDTH-1:0] r_ctrl [N_CTRL];
   logic [N_CTRL-1:0]     r_ctrl_wr_pulse;
   logic                  r_irq;
   logic                  r_av_prev;

   logic [ADDR_WIDTH-1:0] w_offset;
   logic [5:0]            w_off6;
   logic                  w_in_range;
   logic                  w_hit;
   logic [DATA_WIDTH-1:0] w_rd_val;
   logic                  w_sel_scratch;
   logic                  w_sel_event;
   logic                  w_sel_mask;
   logic [N_CTRL-1:0]     w_sel_ctrl;
   logic [N_EVENTS-1:0]   w_clr;

   // Addresses below the base wrap to large offsets and fall out of range.
   assign w_offset   = address - LP_BASE;
   assign w_off6     = w_offset[5:0];
   assign w_in_range = (w_offset < ADDR_WIDTH'(64)) && !w_offset[0];

   always_comb begin
      w_hit         = 1'b0;
      w_rd_val      = '0;
      w_sel_scratch = 1'b0;
      w_sel_event   = 1'b0;
      w_sel_mask    = 1'b0;
      w_sel_ctrl    = '0;
      if (w_in_range) begin
         case (w_off6)
            6'h00: begin w_hit = 1'b1; w_rd_val = LP_ID; end
            6'h02: begin w_hit = 1'b1; w_rd_val = r_scratch; w_sel_scratch = 1'b1; end
            6'h04: begin w_hit = 1'b1; w_rd_val = DATA_WIDTH'(r_event); w_sel_event = 1'b1; end
            6'h06: begin w_hit = 1'b1; w_rd_val = DATA_WIDTH'(r_mask); w_sel_mask = 1'b1; end
            6'h08: begin w_hit = 1'b1; w_rd_val = r_last_addr; end
            default: begin
               for (int i = 0; i < N_CTRL; i++) begin
                  if (w_off6 == 6'(16 + 2 * i)) begin
                     w_hit         = 1'b1;
                     w_rd_val      = r_ctrl[i];
                     w_sel_ctrl[i] = 1'b1;
                  end
               end
               for (int i = 0; i < N_STAT; i++) begin
                  if (w_off6 == 6'(32 + 2 * i)) begin
                     w_hit    = 1'b1;
                     w_rd_val = stat_in[i*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
         endcase
      end
   end

   assign w_clr = (wr_en && w_sel_event) ? wr_data[N_EVENTS-1:0] : '0;

   always_ff @(posedge gpmc_clk) begin
      if (gpmc_reset) begin
         r_rd_data       <= '0;
         r_scratch       <= LP_SCR_RV;
         r_event         <= '0;
         r_mask          <= '0;
         r_last_addr     <= '0;
         r_ctrl_wr_pulse <= '0;
         r_irq           <= 1'b0;
         r_av_prev       <= 1'b1;
         for (int i = 0; i < N_CTRL; i++) r_ctrl[i] <= '0;
      end else begin
         r_rd_data       <= (address_valid && w_hit) ? w_rd_val : '0;
         r_av_prev       <= address_valid;
         r_ctrl_wr_pulse <= wr_en ? w_sel_ctrl : '0;
         // Set wins over a same-cycle write-1-to-clear.
         r_event         <= (r_event & ~w_clr) | event_in;
         r_irq           <= |(r_event & r_mask);
         if (address_valid && !r_av_prev) r_last_addr <= DATA_WIDTH'(address);
         if (wr_en && w_sel_scratch) r_scratch <= wr_data;
         if (wr_en && w_sel_mask) r_mask <= wr_data[N_EVENTS-1:0];
         for (int i = 0; i < N_CTRL; i++) begin
            if (wr_en && w_sel_ctrl[i]) r_ctrl[i] <= wr_data;
         end
      end
   end

   always_comb begin
      ctrl_out = '0;
      for (int i = 0; i < N_CTRL; i++) ctrl_out[i*DATA_WIDTH +: DATA_WIDTH] = r_ctrl[i];
   end

   assign rd_data       = r_rd_data;
   assign ctrl_wr_pulse = r_ctrl_wr_pulse;
   assign irq           = r_irq;

endmodule

// File: doc/gpmc_reg_bank.md
GPMC_REG_BANK -- requirements
Module: gpmc_reg_bank

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 16, host address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, register and data width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, first byte address of the bank; it must be 64-byte aligned.
REQ-004 SHALL have parameter ID_VALUE, default 16'hC10D, value of the ID register.
REQ-005 SHALL have parameter N_CTRL, default 4, range 1..8, number of read/write control registers.
REQ-006 SHALL have parameter N_STAT, default 4, range 1..8, number of read-only status inputs.
REQ-007 SHALL have parameter N_EVENTS, default 8, range 1..DATA_WIDTH, number of sticky event bits.
REQ-008 SHALL have port gpmc_clk, input, 1 bit: the single clock; one clock, all logic on its rising edge.
REQ-009 SHALL have port gpmc_reset, input, 1 bit: reset, synchronous and active-high.
REQ-010 SHALL have port address_valid, input, 1 bit: address phase/read qualifier.
REQ-011 SHALL have port address, input, ADDR_WIDTH bits: byte address.
REQ-012 SHALL have port wr_en, input, 1 bit: single-cycle write strobe.
REQ-013 SHALL have port wr_data, input, DATA_WIDTH bits: write data, valid with wr_en.
REQ-014 SHALL have port rd_data, output, DATA_WIDTH bits: registered read data.
REQ-015 SHALL have port stat_in, input, N_STAT*DATA_WIDTH bits: status words, word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-016 SHALL have port event_in, input, N_EVENTS bits: single-cycle event pulses.
REQ-017 SHALL have port ctrl_out, output, N_CTRL*DATA_WIDTH bits: control register contents, packed like stat_in.
REQ-018 SHALL have port ctrl_wr_pulse, output, N_CTRL bits: one-cycle strobe per control register write.
REQ-019 SHALL have port irq, output, 1 bit: OR of masked pending events.

Function
REQ-020 SHALL decode offset = address - BASE_ADDR. Offsets with address[0]=1, offsets >= 0x40, and unlisted offsets are misses.
REQ-021 SHALL implement the register map:
- 0x00: ID, read-only.
- 0x02: SCRATCH, read/write.
- 0x04: EVENT, sticky, write-1-to-clear.
- 0x06: MASK, read/write, N_EVENTS LSBs.
- 0x08: LAST_ADDR, read-only.
- 0x10+2i: CTRL[i].
- 0x20+2i: STAT[i], read-only.
REQ-022 SHALL register rd_data each cycle as follows:
- If address_valid is high and the address hits, rd_data is the register value on the next cycle (1-cycle latency).
- Otherwise rd_data is 0, so the output can be OR-combined with other banks.
REQ-023 SHALL return zeros in unused upper bits of EVENT, MASK and LAST_ADDR.
REQ-024 SHALL update the target register on the cycle after wr_en when the address hits a writable register; writes to read-only registers and misses are ignored.
REQ-025 SHALL assert ctrl_wr_pulse[i] for exactly one cycle, the same cycle CTRL[i] takes its new value.
REQ-026 SHALL set EVENT[k] whenever event_in[k]=1; a W1C write clears the bits where wr_data[k]=1.
REQ-027 SHALL give set priority when event_in[k] and a W1C of bit k occur in the same cycle: the bit ends at 1.
REQ-028 SHALL register irq = |(EVENT & MASK), one cycle after the EVENT/MASK update.
REQ-029 SHALL capture address into LAST_ADDR on the rising edge of address_valid (high now, low the previous cycle), truncated or zero-extended to DATA_WIDTH.
REQ-030 SHALL have read side effects on no register; reading EVENT does not clear it.
REQ-031 SHALL make a read and a write to the same register in one cycle return the pre-write value.
REQ-032 SHALL sample stat_in in the read cycle; no synchronisation is applied, and the caller supplies gpmc_clk-domain signals.

Reset
REQ-033 SHALL, while gpmc_reset is high at a clock edge, set:
- rd_data = 0, SCRATCH = 16'h1234 (low DATA_WIDTH bits), EVENT = 0, MASK = 0;
- LAST_ADDR = 0, all CTRL = 0, ctrl_wr_pulse = 0, irq = 0;
- the address_valid edge detector = 1, so no capture occurs on the first cycle after reset.
REQ-034 SHALL ignore event_in and wr_en during reset; reset asserted mid-transaction discards the write and forces rd_data to 0 on the next cycle.

Verification
REQ-035 SHALL cover ID/scratch: read 0x00 -> 16'hC10D one cycle later; write 0x02=16'hBEEF, then read 0x02 -> 16'hBEEF; read 0x03 -> 0.
REQ-036 SHALL cover control writes: write CTRL[2]=16'h00A5 -> ctrl_out word 2 = 16'h00A5 and ctrl_wr_pulse=4'b0100 for one cycle; other words unchanged.
REQ-037 SHALL cover events: pulse event_in[3] -> EVENT=16'h0008 and irq=0; write MASK=16'h0008 -> irq=1; W1C 16'h0008 -> EVENT=0, irq=0.
REQ-038 SHALL cover set priority: event_in[1] pulsed in the same cycle as W1C 16'h0002 -> EVENT reads 16'h0002.
REQ-039 SHALL cover misses and read-only registers: with BASE_ADDR=16'h0100, read address 16'h0000 -> 0; write 0x00 and write STAT[0] -> no change in any register.
REQ-040 SHALL cover reset mid-run: set SCRATCH/CTRL/EVENT, assert gpmc_reset for 1 cycle -> SCRATCH=16'h1234, CTRL=0, EVENT=0, irq=0, LAST_ADDR=0.
